// File: rtl/poly_sine_reader_pkg.sv
// Shared types and constants for the polyphonic sine reader.
// Also holds the elaboration-time quarter-wave table generator.
package poly_sine_reader_pkg;

   localparam int DEF_INT_BITS  = 10;
   localparam int DEF_FRAC_BITS = 10;
   localparam int PHASE_WIDTH   = DEF_INT_BITS + DEF_FRAC_BITS;

   typedef enum logic [1:0] {
      QUAD_RISE     = 2'd0,
      QUAD_FALL     = 2'd1,
      QUAD_NEG_RISE = 2'd2,
      QUAD_NEG_FALL = 2'd3
   } quad_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADDR = 2'd1,
      S_DATA = 2'd2
   } state_e;

   localparam logic signed [127:0] PI_Q60 = 128'sh3243F6A8885A308D;

   // round(amp * sin(pi*(2a+1)/2^ib)) using a Q60 Taylor series
   function automatic logic [31:0] sine_entry(
      input int a,
      input int ib,
      input int sw
   );
      logic signed [127:0] x;
      logic signed [127:0] x2;
      logic signed [127:0] term;
      logic signed [127:0] sum;
      logic signed [127:0] amp;
      x    = (PI_Q60 * 128'(2 * a + 1)) >>> ib;
      x2   = (x * x) >>> 60;
      term = x;
      sum  = x;
      for (int k = 1; k < 12; k++) begin
         term = -((term * x2) >>> 60) / 128'(2 * k * (2 * k + 1));
         sum  = sum + term;
      end
      amp = 128'((1 << (sw - 1)) - 1);
      sum = (sum * amp + (128'sd1 <<< 59)) >>> 60;
      return sum[31:0];
   endfunction

endpackage

// File: rtl/poly_sine_reader_rom.sv
// Quarter-wave sine magnitude ROM, one-cycle registered read.
// Contents are computed at elaboration from the half-step sine formula.
module sine_quarter_rom
   import poly_sine_reader_pkg::*;
#(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 15,
   parameter int INT_BITS   = 10
) (
   input  logic                  clk_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   output logic [DATA_WIDTH-1:0] data_o
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] table_w [DEPTH];
   logic [DATA_WIDTH-1:0] data_q;

   for (genvar g = 0; g < DEPTH; g++) begin : g_tbl
      localparam logic [31:0] VAL = sine_entry(g, INT_BITS, DATA_WIDTH + 1);
      assign table_w[g] = VAL[DATA_WIDTH-1:0];
   end

   always_ff @(posedge clk_i) begin
      data_q <= table_w[addr_i];
   end

   assign data_o = data_q;

endmodule

// File: rtl/poly_sine_reader.sv
// Polyphonic phase-accumulator sine generator; voices share one
// quarter-wave ROM and one phase adder, mixed into one sample.
module poly_sine_reader
   import poly_sine_reader_pkg::*;
#(
   parameter int NUM_VOICES   = 4,
   parameter int INT_BITS     = DEF_INT_BITS,
   parameter int FRAC_BITS    = DEF_FRAC_BITS,
   parameter int SAMPLE_WIDTH = 16
) (
   input  logic                                     clk,
   input  logic                                     reset,
   input  logic [NUM_VOICES*(INT_BITS+FRAC_BITS)-1:0] step_sizes,
   input  logic [NUM_VOICES-1:0]                    voice_enable,
   input  logic                                     generate_next,
   output logic                                     sample_ready,
   output logic signed [SAMPLE_WIDTH-1:0]           sample,
   output logic                                     busy
);

   localparam int PW    = INT_BITS + FRAC_BITS;
   localparam int AW    = INT_BITS - 2;
   localparam int SH    = $clog2(NUM_VOICES);
   localparam int VW    = (SH > 0) ? SH : 1;
   localparam int ACC_W = SAMPLE_WIDTH + SH;
   localparam logic [VW-1:0] LAST_V = VW'(NUM_VOICES - 1);

   state_e                          state_q;
   logic [VW-1:0]                   voice_q;
   logic [PW-1:0]                   phase_q [NUM_VOICES];
   logic [PW-1:0]                   step_q  [NUM_VOICES];
   logic [NUM_VOICES-1:0]           en_q;
   logic signed [ACC_W-1:0]         acc_q;
   logic                            neg_q;
   logic                            ready_q;
   logic                            busy_q;
   logic signed [SAMPLE_WIDTH-1:0]  sample_q;

   logic [PW-1:0]                   cur_phase;
   logic [PW-1:0]                   phase_d;
   quad_e                           quad;
   logic [AW-1:0]                   rom_addr;
   logic [SAMPLE_WIDTH-2:0]         rom_data;
   logic signed [ACC_W-1:0]         mag;
   logic signed [ACC_W-1:0]         term;
   logic signed [ACC_W-1:0]         acc_d;

   sine_quarter_rom #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (SAMPLE_WIDTH - 1),
      .INT_BITS   (INT_BITS)
   ) u_rom (
      .clk_i  (clk),
      .addr_i (rom_addr),
      .data_o (rom_data)
   );

   always_comb begin
      cur_phase = phase_q[voice_q];
      quad      = quad_e'(cur_phase[PW-1 -: 2]);
      rom_addr  = cur_phase[PW-3 -: AW];
      if ((quad == QUAD_FALL) || (quad == QUAD_NEG_FALL)) begin
         rom_addr = ~rom_addr;
      end
      // disabled voices restart from phase 0 when re-enabled
      phase_d = en_q[voice_q] ? (cur_phase + step_q[voice_q]) : '0;
      mag     = $signed({{(SH + 1){1'b0}}, rom_data});
      term    = '0;
      if (en_q[voice_q]) begin
         term = neg_q ? -mag : mag;
      end
      acc_d = acc_q + term;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         voice_q  <= '0;
         en_q     <= '0;
         acc_q    <= '0;
         neg_q    <= 1'b0;
         ready_q  <= 1'b0;
         busy_q   <= 1'b0;
         sample_q <= '0;
         for (int v = 0; v < NUM_VOICES; v++) begin
            phase_q[v] <= '0;
            step_q[v]  <= '0;
         end
      end else begin
         ready_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (generate_next) begin
                  for (int v = 0; v < NUM_VOICES; v++) begin
                     step_q[v] <= step_sizes[v*PW +: PW];
                  end
                  en_q    <= voice_enable;
                  voice_q <= '0;
                  acc_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= S_ADDR;
               end
            end
            S_ADDR: begin
               phase_q[voice_q] <= phase_d;
               neg_q   <= (quad == QUAD_NEG_RISE) || (quad == QUAD_NEG_FALL);
               state_q <= S_DATA;
            end
            S_DATA: begin
               if (voice_q == LAST_V) begin
                  sample_q <= SAMPLE_WIDTH'(acc_d >>> SH);
                  ready_q  <= 1'b1;
                  busy_q   <= 1'b0;
                  state_q  <= S_IDLE;
               end else begin
                  acc_q   <= acc_d;
                  voice_q <= voice_q + 1'b1;
                  state_q <= S_ADDR;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign sample_ready = ready_q;
   assign sample       = sample_q;
   assign busy         = busy_q;

endmodule

// File: doc/poly_sine_reader.md
# poly_sine_reader

Parametrised, polyphonic successor to the single-voice sine reader: NUM_VOICES independent 10.10 fixed-point phase accumulators share one quarter-wave sine ROM, time-multiplexed, and their outputs are mixed into one signed sample per generate_next request. It sits between the note/key decoder, which supplies per-voice step sizes and enables, and the audio codec sample path, which issues generate_next.

## Interface
- NUM_VOICES, 4, voice count; power of two, ≥1
- INT_BITS, 10, integer phase bits; top two bits select the quadrant
- FRAC_BITS, 10, fractional phase bits
- SAMPLE_WIDTH, 16, signed output width; ROM magnitude is SAMPLE_WIDTH-1 bits
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- step_sizes  in  NUM_VOICES*(INT_BITS+FRAC_BITS)  voice v at slice [v*20 +: 20]; {int, frac} phase increment per sample
- voice_enable  in  NUM_VOICES  1 = voice v sounds
- generate_next  in  1  request one mixed sample
- sample_ready  out  1  one-cycle pulse; sample valid from this cycle
- sample  out  SAMPLE_WIDTH  signed mixed sample; held until next sample_ready
- busy  out  1  request in progress; generate_next ignored

## Operation
- FSM states IDLE, ADDR, DATA. Reset: IDLE, all phases 0, sample 0, sample_ready 0, busy 0.
- IDLE + generate_next: latch step_sizes and voice_enable, voice index 0, accumulator 0, go ADDR.
- ADDR (voice v): present ROM address from pre-increment phase[v]. If enabled, phase[v] ← phase[v] + step[v] mod 2^(INT_BITS+FRAC_BITS); if disabled, phase[v] ← 0 (coherent restart on re-enable). Go DATA.
- DATA (voice v): ROM word valid; apply quadrant sign; add to accumulator if enabled, else add 0. If v < NUM_VOICES-1: v+1, go ADDR. Else register sample ← (acc + term) >>> log2(NUM_VOICES) (arithmetic, floor), pulse sample_ready, go IDLE.
- Quadrant mapping, p = phase[MSB -: INT_BITS], q = p[INT_BITS-1:INT_BITS-2], a = remaining bits: q0 → +rom[a]; q1 → +rom[~a]; q2 → −rom[a]; q3 → −rom[~a].
- ROM entry a = round((2^(SAMPLE_WIDTH-1)−1)·sin(2π(a+0.5)/2^INT_BITS)); the half-step offset makes mirroring exact. For defaults: 256 entries, rom[0] = 101, rom[255] = 32767.
- Accumulator width SAMPLE_WIDTH + log2(NUM_VOICES); overflow impossible, no saturation.
- Step/enable changes during busy do not affect the request in flight.

## Timing
- generate_next accepted at cycle t (IDLE): voice k ADDR at t+1+2k, DATA at t+2+2k.
- sample_ready high exactly at t+2·NUM_VOICES+1 (t+9 for defaults); FSM already in IDLE, so generate_next in that cycle is accepted.
- busy high t+1 … t+2·NUM_VOICES inclusive; generate_next during busy is dropped, not queued.
- generate_next held high continuously: one sample every 2·NUM_VOICES+1 cycles.
- Reset mid-request: abort, no sample_ready, all state to reset values.

## Structure
- Shared package: PHASE_WIDTH = INT_BITS+FRAC_BITS, quadrant encoding constants, FSM state encoding.
- One sub-module: sine_quarter_rom (address INT_BITS-2 bits, registered output, 1-cycle latency, contents from init file generated by the formula above).
- Phase array as NUM_VOICES registers indexed by voice counter; single adder shared across voices.

## Test plan
- Reset: hold reset 4 cycles with generate_next pulsing → sample 0, sample_ready 0, busy 0 throughout; first post-reset request yields phase-0 values.
- Voice 0 only, step {10'd256,10'd0}, defaults → successive samples 25, 8191, −26, −8192, repeating; sample_ready exactly 9 cycles after each accepted request.
- All four voices enabled, identical step {10'd256,10'd0} → samples 101, 32767, −101, −32767.
- Voice 0 step 20'hFFFFF (wrap) → samples 25 then −26 (phase wraps 0 → 0xFFFFF, quadrant 3, a = 255 mirrored).
- Voice 0 running, voice_enable[0] low for one request then high → disabled request yields 0; next yields 25 (phase restarted).
- generate_next held high 50 cycles, then reset at t+4 of a request → samples every 9 cycles, no sample_ready for the aborted request, outputs 0 after reset.
